// File: rtl/hit_detector.sv
// Purpose: synchronise and debounce player buttons, then score presses against the lit hole.
// Latency: a raw press held from edge 0 gives a registered hit/miss pulse after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; every input is sampled each cycle and the block never stalls.
module hit_detector #(
    parameter int NUM_HOLES       = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_HOLES-1:0]         btn,
    input  logic                         game_active,
    input  logic                         mole_new,
    input  logic [NUM_HOLES-1:0]         mole_onehot,
    output logic                         hit,
    output logic                         miss,
    output logic                         enable_score,
    output logic [$clog2(NUM_HOLES)-1:0] hit_hole
);

    localparam int IDX_W = $clog2(NUM_HOLES);
    // Counter only has to reach DEBOUNCE_CYCLES-1; the accepting cycle clears it.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [NUM_HOLES-1:0] sync1;
    logic [NUM_HOLES-1:0] sync2;
    logic [NUM_HOLES-1:0] deb;
    logic [NUM_HOLES-1:0] deb_prev;
    logic [NUM_HOLES-1:0] press;
    logic [CNT_W-1:0]     cnt [NUM_HOLES];
    logic [NUM_HOLES-1:0] target;
    state_t               state;

    logic                 one_event;
    logic                 on_target;
    logic [IDX_W-1:0]     press_idx;

    // Two-flop synchroniser on the raw asynchronous buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Per-button debouncer: accept a new level only after it differs for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Registered rising-edge detect on the debounced levels; releases produce nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb_prev <= '0;
            press    <= '0;
        end else begin
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
        end
    end

    // Classify this cycle's press events: single vs. mash, on-target, and the pressed index.
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
        one_event = (press != '0) && ((press & (press - 1'b1)) == '0);
        on_target = |(press & target);
    end

    // Appearance FSM with registered strobes; inactive game, then a new mole, take priority over presses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            target       <= '0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            enable_score <= 1'b0;
            hit_hole     <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (!game_active) begin
                state        <= IDLE;
                target       <= '0;
                enable_score <= 1'b0;
            end else if (mole_new) begin
                target <= mole_onehot;
                if (mole_onehot != '0) begin
                    state        <= ARMED;
                    enable_score <= 1'b1;
                end else begin
                    state        <= IDLE;
                    enable_score <= 1'b0;
                end
            end else begin
                case (state)
                    ARMED: begin
                        if (one_event && on_target) begin
                            hit          <= 1'b1;
                            hit_hole     <= press_idx;
                            state        <= LOCKED;
                            enable_score <= 1'b0;
                        end else if (press != '0) begin
                            // Wrong hole, or several holes in one cycle (anti-mash).
                            miss <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        enable_score <= 1'b0;
                    end
                    default: begin
                        state        <= IDLE;
                        enable_score <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hit_detector.sv
module tb_hit_detector;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       game_active;
    logic       mole_new;
    logic [3:0] mole_onehot;
    logic       hit;
    logic       miss;
    logic       enable_score;
    logic [1:0] hit_hole;

    int checks = 0;
    int errors = 0;

    hit_detector #(
        .NUM_HOLES      (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .game_active (game_active),
        .mole_new    (mole_new),
        .mole_onehot (mole_onehot),
        .hit         (hit),
        .miss        (miss),
        .enable_score(enable_score),
        .hit_hole    (hit_hole)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row: inputs held for n cycles; final outputs and pulse counts over the row.
    typedef struct {
        logic [3:0] b;
        logic       ga;
        logic       mn;
        logic [3:0] oh;
        int         n;
        logic       e_hit;
        logic       e_miss;
        logic       e_en;
        logic [1:0] e_hh;
        int         e_nh;
        int         e_nm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] b, input logic ga, input logic mn,
                                input logic [3:0] oh, input int n,
                                input logic eh, input logic em, input logic ee,
                                input logic [1:0] hh, input int nh, input int nm);
        vec_t v;
        v.b = b; v.ga = ga; v.mn = mn; v.oh = oh; v.n = n;
        v.e_hit = eh; v.e_miss = em; v.e_en = ee; v.e_hh = hh;
        v.e_nh = nh; v.e_nm = nm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a row just after a rising edge, count pulses one step after each edge, then check.
    task automatic apply(input string tag, input vec_t v);
        int nh;
        int nm;
        nh = 0;
        nm = 0;
        btn         = v.b;
        game_active = v.ga;
        mole_new    = v.mn;
        mole_onehot = v.oh;
        for (int c = 0; c < v.n; c++) begin
            @(posedge clk);
            #1;
            mole_new = 1'b0;
            if (hit === 1'b1) nh++;
            if (miss === 1'b1) nm++;
            chk({tag, "_hit_and_miss"}, {31'd0, hit & miss}, 32'd0);
        end
        chk({tag, "_hit"},      {31'd0, hit},          {31'd0, v.e_hit});
        chk({tag, "_miss"},     {31'd0, miss},         {31'd0, v.e_miss});
        chk({tag, "_en"},       {31'd0, enable_score}, {31'd0, v.e_en});
        chk({tag, "_hit_hole"}, {30'd0, hit_hole},     {30'd0, v.e_hh});
        chk({tag, "_n_hits"},   nh,                    v.e_nh);
        chk({tag, "_n_misses"}, nm,                    v.e_nm);
    endtask

    task automatic run_tbl(input string prefix);
        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("%s%0d", prefix, i), tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        reset       = 1'b0;
        btn         = 4'b0;
        game_active = 1'b0;
        mole_new    = 1'b0;
        mole_onehot = 4'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hit",      {31'd0, hit},          32'd0);
        chk("reset_miss",     {31'd0, miss},         32'd0);
        chk("reset_en",       {31'd0, enable_score}, 32'd0);
        chk("reset_hit_hole", {30'd0, hit_hole},     32'd0);
        reset = 1'b1;

        // Basic hit, re-press while locked, wrong hole, mash, then correct hole
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0100,  1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 4'b0000,  7, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 4'b0000,  1, 1, 0, 0, 2, 1, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 12, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 12, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0001,  1, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(4'b1000, 1, 0, 4'b0000, 12, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(4'b0110, 1, 0, 4'b0000, 12, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 0, 4'b0000,  8, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0001, 1, 0, 4'b0000,  4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0010,  1, 0, 0, 1, 0, 0, 0));
        run_tbl("basic");

        // Debounce: five 3-cycle glitches on btn[1] while armed give no event
        for (int k = 0; k < 5; k++) begin
            apply($sformatf("glitch%0d_hi", k), mk(4'b0010, 1, 0, 4'b0000, 3, 0, 0, 1, 0, 0, 0));
            apply($sformatf("glitch%0d_lo", k), mk(4'b0000, 1, 0, 4'b0000, 3, 0, 0, 1, 0, 0, 0));
        end

        // Held button: exactly one event; then mole_new colliding with a press event
        tbl.push_back(mk(4'b0010, 1, 0, 4'b0000, 10, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0001,  1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 0, 4'b0000,  7, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 1, 4'b1000,  1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 0, 4'b0000,  6, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 1, 0, 4'b0000,  8, 1, 0, 0, 3, 1, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 3, 0, 0));
        // Gating: game inactive, then an empty mole
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0100,  1, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 0, 4'b0000, 12, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 4'b0000,  8, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 4'b0100,  1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0000,  1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 12, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 3, 0, 0));
        // Reach LOCKED with btn[2] still held
        tbl.push_back(mk(4'b0000, 1, 1, 4'b0100,  1, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 4'b0000,  8, 1, 0, 0, 2, 1, 0));
        run_tbl("seq");

        // Reset while LOCKED with btn[2] held: outputs clear, post-reset event ignored in IDLE
        reset = 1'b0;
        apply("rst1_hold", mk(4'b0100, 1, 0, 4'b0000, 2, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        apply("rst1_idle", mk(4'b0100, 1, 0, 4'b0000, 20, 0, 0, 0, 0, 0, 0));
        apply("rst1_rel",  mk(4'b0000, 1, 0, 4'b0000,  8, 0, 0, 0, 0, 0, 0));

        // Reset again, arm right after release: held button scores at edge 7 after release
        reset = 1'b0;
        apply("rst2_hold", mk(4'b0100, 1, 0, 4'b0000, 2, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        apply("rst2_arm",  mk(4'b0100, 1, 1, 4'b0100, 1, 0, 0, 1, 0, 0, 0));
        apply("rst2_wait", mk(4'b0100, 1, 0, 4'b0000, 6, 0, 0, 1, 0, 0, 0));
        apply("rst2_hit",  mk(4'b0100, 1, 0, 4'b0000, 1, 1, 0, 0, 2, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
